// File: rtl/pc_next_unit.sv
// pc_next_unit: program counter with next-PC select, run/halt control and retired-instruction counter
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic        jump,
    input  logic [25:0] jtarget,
    input  logic        jr,
    input  logic [31:0] rs_val,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] retired_cnt
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      state;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] next_pc;
    assign pc_plus4   = pc + 32'd4;
    assign br_target  = pc_plus4 + {imm[29:0], 2'b00};
    assign jmp_target = {pc_plus4[31:28], jtarget, 2'b00};
    assign next_pc    = jr ? rs_val : jump ? jmp_target : (branch & zero) ? br_target : pc_plus4;
    assign halted     = (state == HALT);
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
            retired_cnt  <= 32'd0;
        end else if (state == RUN && en) begin
            if (halt_req) begin
                state <= HALT;
            end else if (jr && rs_val[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
                state        <= HALT;
            end else begin
                pc          <= next_pc;
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end
endmodule
